// File: rtl/hook_pkg.sv
// Shared types, constants and the retract-speed helper for the hook trajectory controller.
package hook_pkg;

    localparam int NUM_ANGLES = 51;
    localparam int IDX_W      = 6;
    localparam int POS_W      = 11;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ANGLES - 1);

    // Table entry 0 offset, used for the constant reset position
    localparam int OFF0_X = 32;
    localparam int OFF0_Y = 6;

    typedef enum logic [1:0] {
        SWING   = 2'd0,
        EXTEND  = 2'd1,
        RETRACT = 2'd2
    } hook_state_t;

    typedef enum logic {
        UP   = 1'b0,
        DOWN = 1'b1
    } dir_t;

    // Returns -sgn(v) * max(|v| >> w, floor), floor = 1 if floor_one else (v != 0)
    function automatic logic signed [POS_W-1:0] retract_speed(
        input logic signed [POS_W-1:0] v,
        input logic [1:0]              w,
        input logic                    floor_one
    );
        logic [POS_W-1:0] mag;
        logic [POS_W-1:0] s;
        mag = v[POS_W-1] ? -v : v;
        s   = mag >> w;
        if (s == '0 && (floor_one || mag != '0))
            s = POS_W'(1);
        return v[POS_W-1] ? signed'(s) : -signed'(s);
    endfunction

endpackage

// File: rtl/hook_angle_rom.sv
// Combinational angle table: index -> sprite offset and unit speed along that angle.
module hook_angle_rom
    import hook_pkg::*;
(
    input  logic [IDX_W-1:0]        idx_i,
    output logic signed [POS_W-1:0] off_x_o,
    output logic signed [POS_W-1:0] off_y_o,
    output logic signed [POS_W-1:0] sp_x_o,
    output logic signed [POS_W-1:0] sp_y_o
);

    localparam int HALF = (NUM_ANGLES - 1) / 2;

    localparam int OFF_X_T [26] = '{32, 31, 31, 30, 29, 29, 28, 27, 26, 25, 24, 22, 21,
                                    20, 18, 17, 15, 14, 12, 10,  9,  7,  5,  4,  2,  0};
    localparam int OFF_Y_T [26] = '{ 6,  8,  9, 11, 13, 14, 16, 17, 19, 20, 22, 23, 24,
                                    25, 26, 27, 28, 29, 30, 30, 31, 31, 32, 32, 32, 32};
    localparam int SP_X_T  [26] = '{10, 10, 10,  9,  9,  9,  9,  8,  8,  8,  7,  7,  7,
                                     6,  6,  5,  5,  4,  4,  3,  3,  2,  2,  1,  1,  0};
    localparam int SP_Y_T  [26] = '{ 2,  2,  3,  3,  4,  4,  5,  5,  6,  6,  7,  7,  8,
                                     8,  8,  9,  9,  9,  9,  9, 10, 10, 10, 10, 10, 10};

    logic [4:0]              m;
    logic                    mirror;
    logic signed [POS_W-1:0] ox;
    logic signed [POS_W-1:0] sx;

    // Angles are symmetric about 90 degrees: entry 50-i is entry i with X negated
    always_comb begin
        mirror = 1'b0;
        m      = 5'(idx_i);
        if (idx_i > IDX_LAST) begin
            mirror = 1'b1;
            m      = '0;
        end else if (idx_i > IDX_W'(HALF)) begin
            mirror = 1'b1;
            m      = 5'(IDX_LAST - idx_i);
        end
        ox      = POS_W'(OFF_X_T[m]);
        sx      = POS_W'(SP_X_T[m]);
        off_x_o = mirror ? -ox : ox;
        sp_x_o  = mirror ? -sx : sx;
        off_y_o = POS_W'(OFF_Y_T[m]);
        sp_y_o  = POS_W'(SP_Y_T[m]);
    end

endmodule

// File: rtl/hook_trajectory_ctrl.sv
// Hook sprite trajectory: ping-pong swing over the angle table, launch along the angle,
// retract on collision or screen-edge hit with weight-scaled return speed.
module hook_trajectory_ctrl
    import hook_pkg::*;
#(
    parameter int INITIAL_X  = 288,
    parameter int INITIAL_Y  = 64,
    parameter int SWING_DIV  = 5,
    parameter int EXTEND_MUL = 1,
    parameter int FRAME_W    = 640,
    parameter int FRAME_H    = 480,
    parameter int OBJ_W      = 64,
    parameter int OBJ_H      = 64
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    launch_Cable,
    input  logic                    collision,
    input  logic [1:0]              loadWeight,
    output logic signed [POS_W-1:0] topLeftX,
    output logic signed [POS_W-1:0] topLeftY,
    output logic [1:0]              hookState,
    output logic [IDX_W-1:0]        angleIndex,
    output logic                    grabPulse,
    output logic                    edgePulse,
    output logic                    returnPulse,
    output logic                    loadGrabbed
);

    localparam int CNT_W = (SWING_DIV > 1) ? $clog2(SWING_DIV) : 1;
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SWING_DIV - 1);
    localparam logic signed [POS_W-1:0] PIV_X    = POS_W'(INITIAL_X);
    localparam logic signed [POS_W-1:0] PIV_Y    = POS_W'(INITIAL_Y);
    localparam logic signed [POS_W-1:0] RST_X    = POS_W'(INITIAL_X + OFF0_X);
    localparam logic signed [POS_W-1:0] RST_Y    = POS_W'(INITIAL_Y + OFF0_Y);
    localparam logic signed [POS_W-1:0] X_MAX    = POS_W'(FRAME_W - OBJ_W);
    localparam logic signed [POS_W-1:0] Y_MAX    = POS_W'(FRAME_H - OBJ_H);
    localparam logic signed [POS_W-1:0] MUL      = POS_W'(EXTEND_MUL);

    hook_state_t             state_q, state_d;
    dir_t                    dir_q, dir_d, dir_step;
    logic [IDX_W-1:0]        idx_q, idx_d, idx_step;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [POS_W-1:0] px_q, px_d, py_q, py_d;
    logic signed [POS_W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic signed [POS_W-1:0] rx_q, rx_d, ry_q, ry_d;
    logic                    grab_q, grab_d, edge_hit_q, edge_hit_d, ret_q, ret_d;
    logic                    loaded_q, loaded_d;

    logic signed [POS_W-1:0] off_x_c, off_y_c, sp_x_c, sp_y_c;
    logic signed [POS_W-1:0] off_x_n, off_y_n, sp_x_n_unused, sp_y_n_unused;
    logic signed [POS_W-1:0] nx, ny, ry_next;
    logic                    out_of_frame;

    hook_angle_rom u_rom_cur (
        .idx_i  (idx_q),
        .off_x_o(off_x_c),
        .off_y_o(off_y_c),
        .sp_x_o (sp_x_c),
        .sp_y_o (sp_y_c)
    );

    hook_angle_rom u_rom_nxt (
        .idx_i  (idx_step),
        .off_x_o(off_x_n),
        .off_y_o(off_y_n),
        .sp_x_o (sp_x_n_unused),
        .sp_y_o (sp_y_n_unused)
    );

    always_comb begin
        idx_step = idx_q;
        dir_step = dir_q;
        if (dir_q == UP) begin
            if (idx_q >= IDX_LAST) begin
                idx_step = IDX_LAST - 1'b1;
                dir_step = DOWN;
            end else begin
                idx_step = idx_q + 1'b1;
            end
        end else begin
            if (idx_q == '0) begin
                idx_step = IDX_W'(1);
                dir_step = UP;
            end else begin
                idx_step = idx_q - 1'b1;
            end
        end
    end

    assign nx           = px_q + vx_q;
    assign ny           = py_q + vy_q;
    assign ry_next      = py_q + ry_q;
    assign out_of_frame = nx[POS_W-1] || (nx > X_MAX) || (ny > Y_MAX);

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        px_d       = px_q;
        py_d       = py_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        loaded_d   = loaded_q;
        grab_d     = 1'b0;
        edge_hit_d = 1'b0;
        ret_d      = 1'b0;
        case (state_q)
            SWING: begin
                if (launch_Cable) begin
                    state_d  = EXTEND;
                    vx_d     = sp_x_c * MUL;
                    vy_d     = sp_y_c * MUL;
                    loaded_d = 1'b0;
                    cnt_d    = '0;
                end else if (startOfFrame) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        idx_d = idx_step;
                        dir_d = dir_step;
                        px_d  = PIV_X + off_x_n;
                        py_d  = PIV_Y + off_y_n;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            EXTEND: begin
                if (collision) begin
                    state_d  = RETRACT;
                    rx_d     = retract_speed(vx_q, loadWeight, 1'b0);
                    ry_d     = retract_speed(vy_q, loadWeight, 1'b1);
                    grab_d   = 1'b1;
                    loaded_d = 1'b1;
                end else if (startOfFrame) begin
                    if (out_of_frame) begin
                        state_d    = RETRACT;
                        rx_d       = retract_speed(vx_q, 2'd0, 1'b0);
                        ry_d       = retract_speed(vy_q, 2'd0, 1'b1);
                        edge_hit_d = 1'b1;
                    end else begin
                        px_d = nx;
                        py_d = ny;
                    end
                end
            end
            RETRACT: begin
                if (startOfFrame) begin
                    if (ry_next <= PIV_Y + off_y_c) begin
                        px_d    = PIV_X + off_x_c;
                        py_d    = PIV_Y + off_y_c;
                        state_d = SWING;
                        ret_d   = 1'b1;
                    end else begin
                        px_d = px_q + rx_q;
                        py_d = ry_next;
                    end
                end
            end
            default: state_d = SWING;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= SWING;
            dir_q      <= UP;
            idx_q      <= '0;
            cnt_q      <= '0;
            px_q       <= RST_X;
            py_q       <= RST_Y;
            vx_q       <= '0;
            vy_q       <= '0;
            rx_q       <= '0;
            ry_q       <= '0;
            grab_q     <= 1'b0;
            edge_hit_q <= 1'b0;
            ret_q      <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            px_q       <= px_d;
            py_q       <= py_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            grab_q     <= grab_d;
            edge_hit_q <= edge_hit_d;
            ret_q      <= ret_d;
            loaded_q   <= loaded_d;
        end
    end

    assign topLeftX    = px_q;
    assign topLeftY    = py_q;
    assign hookState   = state_q;
    assign angleIndex  = idx_q;
    assign grabPulse   = grab_q;
    assign edgePulse   = edge_hit_q;
    assign returnPulse = ret_q;
    assign loadGrabbed = loaded_q;

endmodule

// File: tb/tb_hook_trajectory_ctrl.sv
// Directed self-checking bench for hook_trajectory_ctrl at default parameters.
module tb_hook_trajectory_ctrl;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               launch_Cable;
    logic               collision;
    logic [1:0]         loadWeight;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;
    logic [1:0]         hookState;
    logic [5:0]         angleIndex;
    logic               grabPulse;
    logic               edgePulse;
    logic               returnPulse;
    logic               loadGrabbed;

    int checks   = 0;
    int failures = 0;

    hook_trajectory_ctrl dut (
        .clk         (clk),
        .resetN      (resetN),
        .startOfFrame(startOfFrame),
        .launch_Cable(launch_Cable),
        .collision   (collision),
        .loadWeight  (loadWeight),
        .topLeftX    (topLeftX),
        .topLeftY    (topLeftY),
        .hookState   (hookState),
        .angleIndex  (angleIndex),
        .grabPulse   (grabPulse),
        .edgePulse   (edgePulse),
        .returnPulse (returnPulse),
        .loadGrabbed (loadGrabbed)
    );

    always #5 clk = ~clk;

    task automatic frame();
        @(negedge clk) startOfFrame = 1'b1;
        @(negedge clk) startOfFrame = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic do_reset();
        startOfFrame = 1'b0; launch_Cable = 1'b0; collision = 1'b0; loadWeight = 2'd0;
        resetN = 1'b0;
        @(negedge clk);
        @(negedge clk) resetN = 1'b1;
        @(negedge clk);
    endtask

    task automatic launch_pulse();
        @(negedge clk) launch_Cable = 1'b1;
        @(negedge clk) launch_Cable = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (topLeftX !== 11'sd320) begin failures++; $display("FAIL reset_x got=%0d exp=320", topLeftX); end
        checks++; if (topLeftY !== 11'sd70) begin failures++; $display("FAIL reset_y got=%0d exp=70", topLeftY); end
        checks++; if (hookState !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", hookState); end
        checks++; if (angleIndex !== 6'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", angleIndex); end
        checks++; if ({grabPulse, edgePulse, returnPulse, loadGrabbed} !== 4'b0000)
            begin failures++; $display("FAIL reset_flags got=%b exp=0000", {grabPulse, edgePulse, returnPulse, loadGrabbed}); end
    endtask

    task automatic test_swing();
        frames(4);
        checks++; if (angleIndex !== 6'd0) begin failures++; $display("FAIL swing_hold got=%0d exp=0", angleIndex); end
        frames(1);
        checks++; if (angleIndex !== 6'd1) begin failures++; $display("FAIL swing_step got=%0d exp=1", angleIndex); end
        checks++; if (topLeftX !== 11'sd319 || topLeftY !== 11'sd72)
            begin failures++; $display("FAIL swing_s1 got=(%0d,%0d) exp=(319,72)", topLeftX, topLeftY); end
        frames(245);
        checks++; if (angleIndex !== 6'd50) begin failures++; $display("FAIL swing_top got=%0d exp=50", angleIndex); end
        checks++; if (topLeftX !== 11'sd256 || topLeftY !== 11'sd70)
            begin failures++; $display("FAIL swing_s50 got=(%0d,%0d) exp=(256,70)", topLeftX, topLeftY); end
        frames(5);
        checks++; if (angleIndex !== 6'd49) begin failures++; $display("FAIL swing_reverse got=%0d exp=49", angleIndex); end
        checks++; if (topLeftX !== 11'sd257 || topLeftY !== 11'sd72)
            begin failures++; $display("FAIL swing_s49 got=(%0d,%0d) exp=(257,72)", topLeftX, topLeftY); end
    endtask

    task automatic test_grab();
        do_reset();
        launch_pulse();
        checks++; if (hookState !== 2'd1) begin failures++; $display("FAIL launch_state got=%0d exp=1", hookState); end
        checks++; if (topLeftX !== 11'sd320) begin failures++; $display("FAIL launch_nomove got=%0d exp=320", topLeftX); end
        frames(3);
        checks++; if (topLeftX !== 11'sd350 || topLeftY !== 11'sd76)
            begin failures++; $display("FAIL extend_pos got=(%0d,%0d) exp=(350,76)", topLeftX, topLeftY); end
        @(negedge clk) begin collision = 1'b1; loadWeight = 2'd1; end
        @(negedge clk) begin collision = 1'b0; loadWeight = 2'd0; end
        checks++; if (grabPulse !== 1'b1 || hookState !== 2'd2 || loadGrabbed !== 1'b1)
            begin failures++; $display("FAIL grab got=gp%b st%0d lg%b exp=gp1 st2 lg1", grabPulse, hookState, loadGrabbed); end
        frame();
        checks++; if (topLeftX !== 11'sd345 || topLeftY !== 11'sd75 || grabPulse !== 1'b0)
            begin failures++; $display("FAIL retract_w1 got=(%0d,%0d) gp%b exp=(345,75) gp0", topLeftX, topLeftY, grabPulse); end
        frames(4);
        checks++; if (topLeftX !== 11'sd325 || topLeftY !== 11'sd71 || returnPulse !== 1'b0)
            begin failures++; $display("FAIL retract_5 got=(%0d,%0d) rp%b exp=(325,71) rp0", topLeftX, topLeftY, returnPulse); end
        frame();
        checks++; if (topLeftX !== 11'sd320 || topLeftY !== 11'sd70 || returnPulse !== 1'b1 || hookState !== 2'd0 || loadGrabbed !== 1'b1)
            begin failures++; $display("FAIL return got=(%0d,%0d) rp%b st%0d lg%b exp=(320,70) rp1 st0 lg1",
                                       topLeftX, topLeftY, returnPulse, hookState, loadGrabbed); end
        launch_pulse();
        checks++; if (loadGrabbed !== 1'b0 || hookState !== 2'd1)
            begin failures++; $display("FAIL relaunch got=lg%b st%0d exp=lg0 st1", loadGrabbed, hookState); end
    endtask

    task automatic test_edge();
        do_reset();
        launch_pulse();
        frames(25);
        checks++; if (topLeftX !== 11'sd570 || topLeftY !== 11'sd120)
            begin failures++; $display("FAIL edge_approach got=(%0d,%0d) exp=(570,120)", topLeftX, topLeftY); end
        frame();
        checks++; if (edgePulse !== 1'b1 || grabPulse !== 1'b0 || hookState !== 2'd2 || topLeftX !== 11'sd570 || topLeftY !== 11'sd120)
            begin failures++; $display("FAIL edge_hit got=ep%b gp%b st%0d (%0d,%0d) exp=ep1 gp0 st2 (570,120)",
                                       edgePulse, grabPulse, hookState, topLeftX, topLeftY); end
        frame();
        checks++; if (topLeftX !== 11'sd560 || topLeftY !== 11'sd118 || edgePulse !== 1'b0)
            begin failures++; $display("FAIL edge_retract got=(%0d,%0d) ep%b exp=(560,118) ep0", topLeftX, topLeftY, edgePulse); end
        frames(23);
        checks++; if (topLeftX !== 11'sd330 || topLeftY !== 11'sd72)
            begin failures++; $display("FAIL edge_near got=(%0d,%0d) exp=(330,72)", topLeftX, topLeftY); end
        frame();
        checks++; if (topLeftX !== 11'sd320 || topLeftY !== 11'sd70 || returnPulse !== 1'b1 || loadGrabbed !== 1'b0)
            begin failures++; $display("FAIL edge_return got=(%0d,%0d) rp%b lg%b exp=(320,70) rp1 lg0",
                                       topLeftX, topLeftY, returnPulse, loadGrabbed); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        launch_pulse();
        frames(2);
        @(negedge clk) begin startOfFrame = 1'b1; collision = 1'b1; loadWeight = 2'd0; end
        @(negedge clk) begin startOfFrame = 1'b0; collision = 1'b0; end
        checks++; if (topLeftX !== 11'sd340 || topLeftY !== 11'sd74 || hookState !== 2'd2 || grabPulse !== 1'b1)
            begin failures++; $display("FAIL coincide got=(%0d,%0d) st%0d gp%b exp=(340,74) st2 gp1",
                                       topLeftX, topLeftY, hookState, grabPulse); end
        @(negedge clk) collision = 1'b1;
        @(negedge clk) collision = 1'b0;
        checks++; if (grabPulse !== 1'b0 || hookState !== 2'd2)
            begin failures++; $display("FAIL retract_ignore_coll got=gp%b st%0d exp=gp0 st2", grabPulse, hookState); end
        frame();
        checks++; if (topLeftX !== 11'sd330 || topLeftY !== 11'sd72)
            begin failures++; $display("FAIL coincide_retract got=(%0d,%0d) exp=(330,72)", topLeftX, topLeftY); end
        frame();
        checks++; if (topLeftX !== 11'sd320 || topLeftY !== 11'sd70 || hookState !== 2'd0 || returnPulse !== 1'b1)
            begin failures++; $display("FAIL coincide_return got=(%0d,%0d) st%0d rp%b exp=(320,70) st0 rp1",
                                       topLeftX, topLeftY, hookState, returnPulse); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        launch_pulse();
        frames(2);
        @(negedge clk);
        #1 resetN = 1'b0;
        #1;
        checks++; if (topLeftX !== 11'sd320 || topLeftY !== 11'sd70 || hookState !== 2'd0 || angleIndex !== 6'd0)
            begin failures++; $display("FAIL async_reset got=(%0d,%0d) st%0d idx%0d exp=(320,70) st0 idx0",
                                       topLeftX, topLeftY, hookState, angleIndex); end
        @(negedge clk) resetN = 1'b1;
        @(negedge clk);
        checks++; if (hookState !== 2'd0) begin failures++; $display("FAIL post_reset_state got=%0d exp=0", hookState); end
        launch_pulse();
        frames(2);
        @(negedge clk) begin collision = 1'b1; loadWeight = 2'd2; end
        @(negedge clk) begin collision = 1'b0; loadWeight = 2'd0; launch_Cable = 1'b1; end
        frame();
        checks++; if (topLeftX !== 11'sd338 || topLeftY !== 11'sd73 || hookState !== 2'd2 || loadGrabbed !== 1'b1)
            begin failures++; $display("FAIL launch_in_retract got=(%0d,%0d) st%0d lg%b exp=(338,73) st2 lg1",
                                       topLeftX, topLeftY, hookState, loadGrabbed); end
        launch_Cable = 1'b0;
        frames(2);
        checks++; if (topLeftX !== 11'sd334 || topLeftY !== 11'sd71)
            begin failures++; $display("FAIL retract_w2 got=(%0d,%0d) exp=(334,71)", topLeftX, topLeftY); end
        frame();
        checks++; if (topLeftX !== 11'sd320 || topLeftY !== 11'sd70 || returnPulse !== 1'b1)
            begin failures++; $display("FAIL w2_return got=(%0d,%0d) rp%b exp=(320,70) rp1", topLeftX, topLeftY, returnPulse); end
    endtask

    initial begin
        test_reset();
        test_swing();
        test_grab();
        test_edge();
        test_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
